// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: address width and FSM state type.
package MiniLab_defs;

  localparam int unsigned DMEM_DEPTH = 8;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: A-priority with starvation guard, optional lock, 1-cycle read return.
// Define DMEM_ARB_RR_EN to replace fixed priority in ARB with round-robin.
module dmem_arbiter
  import MiniLab_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic                  a_lock_i,
  input  logic [DMEM_DEPTH-1:0] a_addr_i,
  input  logic [15:0]           a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [15:0]           a_rdata_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic                  b_lock_i,
  input  logic [DMEM_DEPTH-1:0] b_addr_i,
  input  logic [15:0]           b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [15:0]           b_rdata_o,
  output logic                  mem_we_o,
  output logic [DMEM_DEPTH-1:0] mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  input  logic [15:0]           mem_rdata_i
);

  dmem_arb_state_t state_q, state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             a_rvalid_q, b_rvalid_q;
  logic             a_own, b_own, arb_a, arb_b, gnt_a, gnt_b;

`ifdef DMEM_ARB_RR_EN
  logic last_b;

  always_comb begin
    arb_a = a_req_i && (!b_req_i || last_b);
    arb_b = b_req_i && (!a_req_i || !last_b);
  end
`else
  logic force_b;

  always_comb begin
    force_b = b_req_i && (starve_cnt >= CNT_W'(STARVE_LIMIT));
    arb_b   = force_b || (b_req_i && !a_req_i);
    arb_a   = a_req_i && !force_b;
  end
`endif

  // A lock only holds while its owner keeps both req and lock high; otherwise the cycle is arbitrated.
  always_comb begin
    a_own = (state_q == LOCK_A) && a_req_i && a_lock_i;
    b_own = (state_q == LOCK_B) && b_req_i && b_lock_i;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (a_own) begin
        gnt_a = 1'b1;
      end else if (b_own) begin
        gnt_b = 1'b1;
      end else begin
        gnt_a = arb_a;
        gnt_b = arb_b;
      end
    end
  end

  always_comb begin
    state_d = ARB;
    if (gnt_a && a_lock_i) begin
      state_d = LOCK_A;
    end else if (gnt_b && b_lock_i) begin
      state_d = LOCK_B;
    end
  end

  assign a_gnt_o     = gnt_a;
  assign b_gnt_o     = gnt_b;
  assign mem_we_o    = (gnt_a && a_we_i) || (gnt_b && b_we_i);
  assign mem_addr_o  = gnt_b ? b_addr_i  : a_addr_i;
  assign mem_wdata_o = gnt_b ? b_wdata_i : a_wdata_i;

  // Reset masks a valid already sitting in the return register.
  assign a_rvalid_o = a_rvalid_q && rst_n;
  assign b_rvalid_o = b_rvalid_q && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB;
      starve_cnt <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_o  <= '0;
      b_rdata_o  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_b     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (state_q != LOCK_B) begin
        if (b_req_i && !gnt_b) begin
          if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end else begin
          starve_cnt <= '0;
        end
      end
      a_rvalid_q <= gnt_a && !a_we_i;
      b_rvalid_q <= gnt_b && !b_we_i;
      if (gnt_a && !a_we_i) begin
        a_rdata_o <= mem_rdata_i;
      end
      if (gnt_b && !b_we_i) begin
        b_rdata_o <= mem_rdata_i;
      end
`ifdef DMEM_ARB_RR_EN
      if (gnt_b) begin
        last_b <= 1'b1;
      end else if (gnt_a) begin
        last_b <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a negedge data-memory model and a reference model.
module tb_dmem_arbiter;
  import MiniLab_defs::*;

  localparam int unsigned LIMIT = 8;
  localparam int unsigned CW    = 4;
  localparam int          SAT   = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [DMEM_DEPTH-1:0] a_addr, b_addr;
  logic [15:0]           a_wdata, b_wdata;
  logic                  a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0]           a_rdata, b_rdata;
  logic                  mem_we;
  logic [DMEM_DEPTH-1:0] mem_addr;
  logic [15:0]           mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_lock_i(a_lock), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_lock_i(b_lock), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: single port, updates on negedge, write-first.
  logic [15:0] dmem [256];
  always @(negedge clk) begin
    if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
      mem_rdata      <= mem_wdata;
    end else begin
      mem_rdata <= dmem[mem_addr];
    end
  end

  // Reference model state: who owns the bus, how long B has waited, who went last.
  int          owner;
  int          b_wait;
  bit          last_was_b;
  bit          rv_a, rv_b;
  logic [15:0] rd_a, rd_b;
  logic [15:0] ref_mem [256];
  bit          e_ga, e_gb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_grant();
    e_ga = 1'b0;
    e_gb = 1'b0;
    if (rst_n) begin
      if (owner == 1 && a_req && a_lock)      e_ga = 1'b1;
      else if (owner == 2 && b_req && b_lock) e_gb = 1'b1;
      else begin
`ifdef DMEM_ARB_RR_EN
        if (a_req && b_req) begin
          e_ga = last_was_b;
          e_gb = !last_was_b;
        end else begin
          e_ga = a_req;
          e_gb = b_req;
        end
`else
        if (b_req && b_wait >= LIMIT) e_gb = 1'b1;
        else if (a_req)               e_ga = 1'b1;
        else if (b_req)               e_gb = 1'b1;
`endif
      end
    end
  endtask

  task automatic sample();
    #2;
    model_grant();
    chk("a_gnt", a_gnt, e_ga);
    chk("b_gnt", b_gnt, e_gb);
    chk("mem_we", mem_we, (e_ga && a_we) || (e_gb && b_we));
    chk("mem_addr", mem_addr, e_gb ? b_addr : a_addr);
    chk("mem_wdata", mem_wdata, e_gb ? b_wdata : a_wdata);
    chk("a_rvalid", a_rvalid, rv_a && rst_n);
    chk("b_rvalid", b_rvalid, rv_b && rst_n);
    chk("a_rdata", a_rdata, rd_a);
    chk("b_rdata", b_rdata, rd_b);
  endtask

  task automatic advance();
    if (!rst_n) begin
      owner = 0; b_wait = 0; last_was_b = 1'b1;
      rv_a = 1'b0; rv_b = 1'b0; rd_a = '0; rd_b = '0;
    end else begin
      if (owner != 2) b_wait = (b_req && !e_gb) ? ((b_wait < SAT) ? b_wait + 1 : SAT) : 0;
      owner = (e_ga && a_lock) ? 1 : (e_gb && b_lock) ? 2 : 0;
      if (e_ga) last_was_b = 1'b0;
      if (e_gb) last_was_b = 1'b1;
      rv_a = e_ga && !a_we;
      rv_b = e_gb && !b_we;
      if (rv_a) rd_a = ref_mem[a_addr];
      if (rv_b) rd_b = ref_mem[b_addr];
      if (e_ga && a_we) ref_mem[a_addr] = a_wdata;
      if (e_gb && b_we) ref_mem[b_addr] = b_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst_n, a_req, a_we, a_lock, b_req, b_we, b_lock;
    bit e_ga, e_gb, e_we;
  } vec_t;

  vec_t vecs [14];

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    mem_rdata = '0;
    owner = 0; b_wait = 0; last_was_b = 1'b1;
    rv_a = 1'b0; rv_b = 1'b0; rd_a = '0; rd_b = '0;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 8'd1; a_wdata = 16'h1111;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 8'd2; b_wdata = 16'h2222;

    // Reset with both requesting writes, then both reading continuously.
    vecs[0] = '{0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    for (int k = 1; k <= 12; k++) begin
`ifdef DMEM_ARB_RR_EN
      vecs[k+1] = '{1, 1, 0, 0, 1, 0, 0, (k % 2) == 1, (k % 2) == 0, 0};
`else
      vecs[k+1] = '{1, 1, 0, 0, 1, 0, 0, k != 9, k == 9, 0};
`endif
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      rst_n = vecs[i].rst_n;
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_lock = vecs[i].a_lock;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_lock = vecs[i].b_lock;
      sample();
      chk($sformatf("vec%0d_a_gnt", i), a_gnt, vecs[i].e_ga);
      chk($sformatf("vec%0d_b_gnt", i), b_gnt, vecs[i].e_gb);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_we);
      if (!vecs[i].rst_n) begin
        chk($sformatf("vec%0d_a_rvalid", i), a_rvalid, 1'b0);
        chk($sformatf("vec%0d_b_rvalid", i), b_rvalid, 1'b0);
      end
      advance();
    end

    // A write then read-back of address 5.
    b_req = 0;
    a_req = 1; a_we = 1; a_lock = 0; a_addr = 8'd5; a_wdata = 16'h1234;
    sample();
    chk("wr5_gnt", a_gnt, 1'b1);
    advance();
    a_we = 0;
    sample();
    chk("rd5_gnt", a_gnt, 1'b1);
    advance();
    a_req = 0;
    sample();
    chk("rd5_rvalid", a_rvalid, 1'b1);
    chk("rd5_rdata", a_rdata, 16'h1234);
    chk("rd5_b_rvalid", b_rvalid, 1'b0);
    advance();

    // Preload 10..13, then a locked B read burst while A keeps asking.
    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_we = 1; a_addr = 8'(10 + i); a_wdata = 16'(16'hA000 + i);
      sample();
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      a_req = (i > 0); a_we = 0; a_lock = 0; a_addr = 8'd20;
      b_req = 1; b_we = 0; b_lock = 1; b_addr = 8'(10 + i);
      sample();
      chk($sformatf("burst%0d_b_gnt", i), b_gnt, 1'b1);
      chk($sformatf("burst%0d_a_gnt", i), a_gnt, 1'b0);
      if (i > 0) begin
        chk($sformatf("burst%0d_b_rvalid", i), b_rvalid, 1'b1);
        chk($sformatf("burst%0d_b_rdata", i), b_rdata, 16'(16'hA000 + i - 1));
      end
      advance();
    end
    a_req = 1; b_req = 0; b_lock = 0;
    sample();
    chk("burst_end_a_gnt", a_gnt, 1'b1);
    chk("burst_end_b_rvalid", b_rvalid, 1'b1);
    chk("burst_end_b_rdata", b_rdata, 16'hA003);
    advance();

    // Reset right after a locked A read grant.
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 8'd5; b_req = 0;
    sample();
    chk("prerst_a_gnt", a_gnt, 1'b1);
    advance();
    rst_n = 0;
    sample();
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_a_gnt", a_gnt, 1'b0);
    advance();
    rst_n = 1; a_req = 0; a_lock = 0; b_req = 1; b_we = 0; b_lock = 0; b_addr = 8'd12;
    sample();
    chk("postrst_b_gnt", b_gnt, 1'b1);
    chk("postrst_a_rvalid", a_rvalid, 1'b0);
    advance();

    // Randomized traffic; a denied requester holds its request stable.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if (!(a_req && !e_ga)) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
        a_lock = ($urandom_range(0, 3) == 0);
        a_addr = 8'($urandom_range(0, 15)); a_wdata = 16'($urandom);
      end else begin
        a_lock = ($urandom_range(0, 2) != 0);
      end
      if (!(b_req && !e_gb)) begin
        b_req = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1);
        b_lock = ($urandom_range(0, 3) == 0);
        b_addr = 8'($urandom_range(0, 15)); b_wdata = 16'($urandom);
      end else begin
        b_lock = ($urandom_range(0, 2) != 0);
      end
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
